// File: rtl/simple_adder_deser.sv
// simple_adder_deser: captures an MSB-first serial result stream into parallel
// RES_WIDTH-bit words and buffers them in a small FIFO with valid/ready output.
// An en_i pulse marks the MSB of each frame. Words that complete while the FIFO
// is full, with no pop on that edge, are dropped and set a sticky overrun flag.
// Optional feature: define SIMPLE_ADDER_DESER_PARITY_EN to add parity_o, the
// XOR of the head word's bits, stored with each FIFO entry.
module simple_adder_deser #(
    parameter int RES_WIDTH  = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in,
    input  logic                          en_i,
    output logic [RES_WIDTH-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          overrun_o
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
    ,output logic                         parity_o
`endif
);

    localparam int CW = $clog2(RES_WIDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST  = CW'(RES_WIDTH - 1);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [RES_WIDTH-1:0]  sr;
    logic [RES_WIDTH-1:0]  sr_next;
    logic [CW-1:0]         sh;
    logic                  complete;
    logic [RES_WIDTH-1:0]  word;

    logic [RES_WIDTH-1:0]  mem [FIFO_DEPTH];
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
    logic                  par_mem [FIFO_DEPTH];
`endif
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Bit placement and word-completion decode. Each bit is ORed into its final
    // position; the LSB is taken straight from in on the completing edge, so the
    // shift register's bit 0 is always zero when the word is assembled.
    always_comb begin
        sh       = LAST - cnt;
        sr_next  = sr | (RES_WIDTH'(in) << sh);
        complete = (state == SHIFT) && !en_i && (cnt == LAST);
        word     = {sr[RES_WIDTH-1:1], in};
    end

    // Frame capture FSM: en_i always (re)starts a frame with the current bit as MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        sr    <= {in, {(RES_WIDTH-1){1'b0}}};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en_i) begin
                        sr    <= {in, {(RES_WIDTH-1){1'b0}}};
                        cnt   <= CW'(1);
                    end else if (cnt == LAST) begin
                        sr    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        sr    <= sr_next;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sr    <= '0;
                end
            endcase
        end
    end

    // FIFO control: a pop frees the head slot, so a push on a full FIFO is
    // accepted when it coincides with a pop.
    always_comb begin
        full    = (fill_o == DEPTH);
        valid_o = (fill_o != '0);
        pop     = valid_o && ready_i;
        push    = complete && (!full || pop);
    end

    // FIFO storage, pointers, fill count and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
                par_mem[i] <= 1'b0;
`endif
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
                par_mem[wr_ptr] <= ^word;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fill_o <= fill_o + (PW + 1)'(1);
                2'b01:   fill_o <= fill_o - (PW + 1)'(1);
                default: fill_o <= fill_o;
            endcase
            if (complete && full && !pop) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // Head-of-buffer output, forced to zero while the buffer is empty.
    always_comb begin
        data_o = valid_o ? mem[rd_ptr] : '0;
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
        parity_o = valid_o ? par_mem[rd_ptr] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_simple_adder_deser.sv
// Testbench for simple_adder_deser: directed frames for the key scenarios plus
// randomized traffic, checked every cycle against a queue-based reference model.
module tb_simple_adder_deser;

    localparam int W  = 3;
    localparam int D  = 2;
    localparam int PW = $clog2(D);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in = 1'b0;
    logic           en_i = 1'b0;
    logic           ready_i = 1'b0;
    logic [W-1:0]   data_o;
    logic           valid_o;
    logic [PW:0]    fill_o;
    logic           overrun_o;
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
    logic           parity_o;
`endif

    simple_adder_deser #(.RES_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .en_i      (en_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .fill_o    (fill_o),
        .overrun_o (overrun_o)
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
        ,.parity_o (parity_o)
`endif
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: buffered words, frame-in-progress value and bit count.
    int q[$];
    int part = 0;
    int k    = 0;
    bit ovr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int head;
        head = (q.size() != 0) ? q[0] : 0;
        chk("valid_o", 32'(valid_o), 32'(q.size() != 0));
        chk("fill_o", 32'(fill_o), 32'(q.size()));
        chk("data_o", 32'(data_o), 32'(head));
        chk("overrun_o", 32'(overrun_o), 32'(ovr));
`ifdef SIMPLE_ADDER_DESER_PARITY_EN
        chk("parity_o", 32'(parity_o), 32'(^head));
`endif
    endtask

    task automatic model_edge(input bit e, input bit b, input bit r);
        bit done;
        bit do_pop;
        int w;
        done   = 1'b0;
        w      = 0;
        do_pop = (q.size() > 0) && r;
        if (e) begin
            part = int'(b);
            k    = 1;
        end else if (k > 0) begin
            part = part * 2 + int'(b);
            k++;
        end
        if (k == W) begin
            done = 1'b1;
            w    = part;
            k    = 0;
        end
        if (do_pop) void'(q.pop_front());
        if (done) begin
            if (q.size() < D) q.push_back(w);
            else ovr = 1'b1;
        end
    endtask

    task automatic step(input bit e, input bit b, input bit r);
        en_i    = e;
        in      = b;
        ready_i = r;
        @(posedge clk);
        model_edge(e, b, r);
        #1;
        check_outputs();
    endtask

    task automatic frame(input int val, input bit r);
        for (int i = 0; i < W; i++) begin
            step(i == 0, 1'((val >> (W - 1 - i)) & 1), r);
        end
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        part = 0;
        k    = 0;
        ovr  = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        // Reset from time zero
        #2 rst = 1'b1;
        #1 check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 1);
        step(0, 0, 1);

        // Single frame 101 with ready_i high: one-cycle valid pulse
        frame(5, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Fill with 110, 011 then overrun with 111, then drain
        frame(6, 0);
        frame(3, 0);
        step(0, 0, 0);
        frame(7, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Full FIFO, pop coincides with completion of 010
        pulse_reset();
        frame(6, 0);
        frame(3, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // en_i re-asserted on the second bit: single word 011
        step(1, 1, 1);
        step(1, 0, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 1);

        // Reset mid-frame with one buffered word; bits without en_i afterwards
        frame(5, 0);
        step(1, 1, 0);
        pulse_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 1);

        // Parity frames 111 and 101
        frame(7, 0);
        frame(5, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) == 0, 1'($urandom), $urandom_range(2) != 0);
            if (i == 1500) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
